// File: rtl/dist_ram_reader.sv
// Read sequencer that streams a burst of words out of the distributed RAM
// and registers them into a valid/ready output stage, one word per cycle.
module dist_ram_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_DEPTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]    ram_rd_data,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  // state | meaning
  // IDLE  | waiting for start; zero-length requests complete here
  // FETCH | capturing one RAM word per load into the output stage
  // DRAIN | last word captured, waiting for its handshake
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [ADDRESS_WIDTH:0]   DEPTH_LEN = (ADDRESS_WIDTH+1)'(DATA_DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   ONE_LEN   = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DATA_DEPTH - 1);

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0]    data_nxt;
  logic                     valid_nxt;
  logic                     done_nxt;
  logic [ADDRESS_WIDTH:0]   remaining, remaining_nxt;
  logic [ADDRESS_WIDTH:0]   len_clamped;
  logic                     load;
  logic                     handshake;

  assign len_clamped = (length > DEPTH_LEN) ? DEPTH_LEN : length;
  assign load        = (state == FETCH) && (!out_valid || out_ready);
  assign handshake   = out_valid && out_ready;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    addr_nxt      = ram_rd_addr;
    data_nxt      = out_data;
    valid_nxt     = out_valid;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_clamped != '0) begin
            addr_nxt      = base_addr;
            remaining_nxt = len_clamped;
            state_nxt     = FETCH;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      FETCH: begin
        if (load) begin
          data_nxt      = ram_rd_data;
          valid_nxt     = 1'b1;
          remaining_nxt = remaining - ONE_LEN;
          // Address stays on the final word so the bus is quiet while draining.
          if (remaining == ONE_LEN) begin
            state_nxt = DRAIN;
          end else begin
            addr_nxt = (ram_rd_addr == LAST_ADDR) ? '0 : ram_rd_addr + 1'b1;
          end
        end else if (handshake) begin
          valid_nxt = 1'b0;
        end
      end
      DRAIN: begin
        if (handshake) begin
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ram_rd_addr <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      remaining   <= '0;
    end else begin
      state       <= state_nxt;
      ram_rd_addr <= addr_nxt;
      out_data    <= data_nxt;
      out_valid   <= valid_nxt;
      done        <= done_nxt;
      remaining   <= remaining_nxt;
    end
  end

endmodule

// File: tb/tb_dist_ram_reader.sv
// Directed bench for dist_ram_reader: a RAM model with RAM[i] = i+16 feeds the
// reader and each step checks stream data, addresses, busy and done timing.
module tb_dist_ram_reader;

  localparam int DW = 8;
  localparam int DD = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DD];
  assign ram_rd_data = mem[ram_rd_addr];

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] words[$];
  logic [AW-1:0] addrs[$];
  int busy_cnt, done_at, last_hs;

  dist_ram_reader #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] l);
    start     = 1'b1;
    base_addr = b;
    length    = l;
    tick();
    start = 1'b0;
  endtask

  // Runs until done (or budget); optionally pulses start at cycle inject_c.
  task automatic collect(input int budget, input int inject_c);
    words.delete();
    addrs.delete();
    busy_cnt = 0;
    done_at  = -1;
    last_hs  = -100;
    for (int c = 0; c < budget; c++) begin
      addrs.push_back(ram_rd_addr);
      if (busy) busy_cnt++;
      if (done) begin
        done_at = c;
        break;
      end
      if (out_valid && out_ready) begin
        words.push_back(out_data);
        last_hs = c;
      end
      if (c == inject_c) begin
        start     = 1'b1;
        base_addr = 5'd0;
        length    = 6'd5;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DD; i++) mem[i] = DW'(i + 16);
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_addr",  32'(ram_rd_addr), 0);
    chk("rst_data",  32'(out_data), 0);
    #10;
    rst_n = 1'b1;
    tick();

    // Basic burst: base 3, length 4
    pulse_start(5'd3, 6'd4);
    collect(20, -1);
    chk("basic_count", words.size(), 4);
    if (words.size() == 4) begin
      chk("basic_w0", 32'(words[0]), 19);
      chk("basic_w1", 32'(words[1]), 20);
      chk("basic_w2", 32'(words[2]), 21);
      chk("basic_w3", 32'(words[3]), 22);
    end
    chk("basic_done_lag", done_at - last_hs, 1);
    chk("basic_busy_cycles", busy_cnt, 5);
    tick();
    chk("basic_done_pulse", 32'(done), 0);

    // Wrap: base 30, length 4
    pulse_start(5'd30, 6'd4);
    collect(20, -1);
    chk("wrap_count", words.size(), 4);
    if (words.size() == 4 && addrs.size() >= 4) begin
      chk("wrap_a0", 32'(addrs[0]), 30);
      chk("wrap_a1", 32'(addrs[1]), 31);
      chk("wrap_a2", 32'(addrs[2]), 0);
      chk("wrap_a3", 32'(addrs[3]), 1);
      chk("wrap_w0", 32'(words[0]), 46);
      chk("wrap_w1", 32'(words[1]), 47);
      chk("wrap_w2", 32'(words[2]), 16);
      chk("wrap_w3", 32'(words[3]), 17);
    end

    // Backpressure: base 5, length 3, ready low for the first 3 valid cycles
    out_ready = 1'b0;
    pulse_start(5'd5, 6'd3);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data",  32'(out_data), 21);
      chk("bp_addr",  32'(ram_rd_addr), 6);
    end
    out_ready = 1'b1;
    collect(20, -1);
    chk("bp_count", words.size(), 3);
    if (words.size() == 3) begin
      chk("bp_w0", 32'(words[0]), 21);
      chk("bp_w1", 32'(words[1]), 22);
      chk("bp_w2", 32'(words[2]), 23);
    end
    chk("bp_done_lag", done_at - last_hs, 1);

    // Zero length
    pulse_start(5'd7, 6'd0);
    chk("zero_done",  32'(done), 1);
    chk("zero_busy",  32'(busy), 0);
    chk("zero_valid", 32'(out_valid), 0);
    tick();
    chk("zero_done_pulse", 32'(done), 0);
    chk("zero_busy2", 32'(busy), 0);

    // Clamp: length 40 delivers all 32 words once
    pulse_start(5'd0, 6'd40);
    collect(60, -1);
    chk("clamp_count", words.size(), 32);
    chk("clamp_busy_cycles", busy_cnt, 33);
    if (words.size() == 32) begin
      for (int i = 0; i < 32; i++) chk("clamp_word", 32'(words[i]), 32'(i + 16));
    end

    // Back-to-back with an ignored start while busy
    pulse_start(5'd10, 6'd2);
    collect(20, 0);
    chk("b2b_a_count", words.size(), 2);
    if (words.size() == 2) begin
      chk("b2b_a_w0", 32'(words[0]), 26);
      chk("b2b_a_w1", 32'(words[1]), 27);
    end
    chk("b2b_a_busy_cycles", busy_cnt, 3);
    chk("b2b_a_done", done_at, 3);
    pulse_start(5'd20, 6'd3);
    chk("b2b_b_busy", 32'(busy), 1);
    collect(20, -1);
    chk("b2b_b_count", words.size(), 3);
    if (words.size() == 3) begin
      chk("b2b_b_w0", 32'(words[0]), 36);
      chk("b2b_b_w1", 32'(words[1]), 37);
      chk("b2b_b_w2", 32'(words[2]), 38);
    end

    // Async reset mid-burst
    pulse_start(5'd0, 6'd8);
    tick();
    tick();
    chk("ar_pre_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_busy",  32'(busy), 0);
    chk("ar_done",  32'(done), 0);
    chk("ar_addr",  32'(ram_rd_addr), 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("ar_idle_busy", 32'(busy), 0);
    chk("ar_idle_done", 32'(done), 0);
    pulse_start(5'd4, 6'd2);
    collect(20, -1);
    chk("ar_after_count", words.size(), 2);
    if (words.size() == 2) begin
      chk("ar_after_w0", 32'(words[0]), 20);
      chk("ar_after_w1", 32'(words[1]), 21);
    end
    chk("ar_after_done_lag", done_at - last_hs, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
